traffic_light_monitor: RTL and testbench

- Independent safety checker on the consuming end of the controller's four light buses (M1, S, MT, M2). It watches them the way a signal conflict monitor would.
- Checks each channel for legal encoding, legal colour sequence and minimum yellow dwell. Checks channel pairs for conflicting right-of-way.
- On any violation it latches a fault, records its cause and channel, and raises an all-red flash request until a clear is accepted.

---
 rtl/traffic_light_monitor_if.sv | 12 +
 rtl/traffic_light_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_monitor_if.sv
// Light-bus bundle between the signal controller and the conflict monitor:
// four 3-bit one-hot light buses plus the operator fault-clear strobe.
interface traffic_light_monitor_if;
  logic [2:0] light_M1;
  logic [2:0] light_S;
  logic [2:0] light_MT;
  logic [2:0] light_M2;
  logic       clr_fault;

  modport master (output light_M1, light_S, light_MT, light_M2, clr_fault);
  modport slave  (input  light_M1, light_S, light_MT, light_M2, clr_fault);
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: independent signal-conflict monitor on the four light
// buses (channel index M1=0, S=1, MT=2, M2=3). Checks encoding (glitch
// filtered), colour sequence, minimum yellow dwell and pairwise right-of-way
// conflicts; latches the first fault and requests all-red flash until cleared.
// Optional build macro TLM_STATS_EN adds cycle_cnt, a wrapping count of
// completed side-road phases.

// Per-channel checker: last-valid history, invalid-run counter, yellow dwell.
module tlm_chan #(
  parameter int MIN_YEL_CYC = 100_000_000,
  parameter int GLITCH_CYC  = 4,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,     // INIT: capture history, restart filters
  input  logic       upd,      // MONITOR: advance history and counters
  input  logic [2:0] smp,
  output logic       act,      // valid and not red
  output logic       enc_hit,
  output logic       seq_hit,
  output logic       yel_hit,
  output logic       y2r
);
  localparam int RW = $clog2(GLITCH_CYC + 1);
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

  logic [2:0]       hist;
  logic             hist_vld;
  logic [RW-1:0]    run;
  logic [CNT_W-1:0] yel;
  logic             vld;

  assign vld     = (smp == RED) || (smp == YEL) || (smp == GRN);
  assign act     = vld && (smp != RED);
  // current invalid sample completes a run of GLITCH_CYC
  assign enc_hit = !vld && (run >= RW'(GLITCH_CYC - 1));
  assign seq_hit = vld && hist_vld &&
                   (((hist == GRN) && (smp == RED)) ||
                    ((hist == YEL) && (smp == GRN)) ||
                    ((hist == RED) && (smp == YEL)));
  assign y2r     = vld && hist_vld && (hist == YEL) && (smp == RED);
  assign yel_hit = y2r && (yel < CNT_W'(MIN_YEL_CYC));

  // History and counters; invalid samples freeze history and yellow count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= 3'b000;
      hist_vld <= 1'b0;
      run      <= '0;
      yel      <= '0;
    end else if (load) begin
      run <= '0;
      if (vld) begin
        hist     <= smp;
        hist_vld <= 1'b1;
        yel      <= (smp == YEL) ? CNT_W'(1) : '0;
      end
    end else if (upd) begin
      if (!vld) begin
        if (run < RW'(GLITCH_CYC)) run <= run + RW'(1);
      end else begin
        run      <= '0;
        hist     <= smp;
        hist_vld <= 1'b1;
        if (smp != YEL)                    yel <= '0;
        else if (yel < CNT_W'(MIN_YEL_CYC)) yel <= yel + CNT_W'(1);
      end
    end
  end
endmodule

module traffic_light_monitor #(
  parameter int MIN_YEL_CYC = 100_000_000,
  parameter int GLITCH_CYC  = 4,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  traffic_light_monitor_if.slave  bus,
  output logic                    fault,
  output logic [2:0]              fault_code,
  output logic [1:0]              fault_ch,
  output logic                    flash_red,
  output logic                    cycle_done
`ifdef TLM_STATS_EN
  ,
  output logic [15:0]             cycle_cnt
`endif
);
  localparam int NUM_CH = 4;
  localparam logic [2:0] C_CONF = 3'd1, C_ENC = 3'd2, C_SEQ = 3'd3, C_YEL = 3'd4;

  typedef enum logic [1:0] {S_INIT, S_MON, S_FAULT} state_t;

  state_t                       state, nxt;
  logic [NUM_CH-1:0][2:0]       in_q;
  logic [NUM_CH-1:0]            act, enc_hit, seq_hit, yel_hit, y2r;
  logic                         load, upd, conf_any;
  logic [1:0]                   conf_ch, det_ch;
  logic [2:0]                   det_code;

  function automatic logic [1:0] low_idx(input logic [NUM_CH-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Input stage: every check works on the registered copy of the buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= '0;
    else        in_q <= {bus.light_M2, bus.light_MT, bus.light_S, bus.light_M1};
  end

  tlm_chan #(
    .MIN_YEL_CYC (MIN_YEL_CYC),
    .GLITCH_CYC  (GLITCH_CYC),
    .CNT_W       (CNT_W)
  ) u_chan [NUM_CH-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .upd     (upd),
    .smp     (in_q),
    .act     (act),
    .enc_hit (enc_hit),
    .seq_hit (seq_hit),
    .yel_hit (yel_hit),
    .y2r     (y2r)
  );

  // Conflicting pairs S/M1, S/M2, S/MT, MT/M2; report lower index of the pair.
  assign conf_any = (act[1] & act[0]) | (act[1] & act[3]) |
                    (act[1] & act[2]) | (act[2] & act[3]);
  assign conf_ch  = (act[1] & act[0])            ? 2'd0 :
                    (act[1] & (act[3] | act[2])) ? 2'd1 : 2'd2;

  // Fault priority: CONFLICT > ENC > SEQ > YEL_SHORT, lowest channel first.
  always_comb begin
    det_code = 3'd0;
    det_ch   = 2'd0;
    if (conf_any) begin
      det_code = C_CONF;
      det_ch   = conf_ch;
    end else if (|enc_hit) begin
      det_code = C_ENC;
      det_ch   = low_idx(enc_hit);
    end else if (|seq_hit) begin
      det_code = C_SEQ;
      det_ch   = low_idx(seq_hit);
    end else if (|yel_hit) begin
      det_code = C_YEL;
      det_ch   = low_idx(yel_hit);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= nxt;
  end

  // FSM next state; a clear is refused while a conflict is still on the buses.
  always_comb begin
    nxt  = state;
    load = 1'b0;
    upd  = 1'b0;
    unique case (state)
      S_INIT:  begin load = 1'b1; nxt = S_MON; end
      S_MON:   begin upd = 1'b1; if (det_code != 3'd0) nxt = S_FAULT; end
      S_FAULT: if (bus.clr_fault && !conf_any) nxt = S_INIT;
      default: nxt = S_INIT;
    endcase
  end

  // Registered outputs: latch first fault, drop on accepted clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      flash_red  <= 1'b0;
      fault_code <= 3'd0;
      fault_ch   <= 2'd0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= upd & y2r[1];
      if (upd && (det_code != 3'd0)) begin
        fault      <= 1'b1;
        flash_red  <= 1'b1;
        fault_code <= det_code;
        fault_ch   <= det_ch;
      end else if ((state == S_FAULT) && (nxt == S_INIT)) begin
        fault      <= 1'b0;
        flash_red  <= 1'b0;
        fault_code <= 3'd0;
        fault_ch   <= 2'd0;
      end
    end
  end

`ifdef TLM_STATS_EN
  // Completed side-road phases; survives fault and clear, only reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cycle_cnt <= 16'd0;
    else if (upd & y2r[1])   cycle_cnt <= cycle_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed plan steps plus a random walk,
// every cycle compared against a colour-level reference model.
module tb_traffic_light_monitor;
  localparam int MIN_YEL = 10;
  localparam int GLITCH  = 4;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, BAD = 3'b011;

  logic clk = 1'b0;
  logic rst_n;
  logic fault, flash_red, cycle_done;
  logic [2:0] fault_code;
  logic [1:0] fault_ch;
`ifdef TLM_STATS_EN
  logic [15:0] cycle_cnt;
`endif

  traffic_light_monitor_if bus ();

  traffic_light_monitor #(.MIN_YEL_CYC(MIN_YEL), .GLITCH_CYC(GLITCH), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_ch   (fault_ch),
    .flash_red  (flash_red),
    .cycle_done (cycle_done)
`ifdef TLM_STATS_EN
    ,
    .cycle_cnt  (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dones  = 0;

  // reference model: colours as 0 red, 1 green, 2 yellow, -1 invalid;
  // legal move is "stay" or "one step forward" around R->G->Y->R
  int mst;                // 0 init, 1 monitor, 2 fault
  int hist[4];
  int ycnt[4];
  int run[4];
  logic [3:0][2:0] q;
  int e_fault, e_code, e_ch, e_done, e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int col(input logic [2:0] v);
    case (v)
      3'b100:  return 0;
      3'b001:  return 1;
      3'b010:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    mst = 0;
    for (int i = 0; i < 4; i++) begin hist[i] = -1; ycnt[i] = 0; run[i] = 0; end
    q = '0;
    e_fault = 0; e_code = 0; e_ch = 0; e_done = 0; e_cnt = 0;
  endtask

  // outputs expected after the coming edge, from the sample currently held
  task automatic model_edge(input logic clr);
    int c[4];
    bit act[4];
    int pa[4], pb[4];
    bit conf;
    int cch, code, fch;
    pa = '{1, 1, 1, 2};
    pb = '{0, 3, 2, 3};
    for (int i = 0; i < 4; i++) begin c[i] = col(q[i]); act[i] = (c[i] > 0); end
    conf = 0; cch = 3;
    for (int p = 0; p < 4; p++)
      if (act[pa[p]] && act[pb[p]]) begin
        conf = 1;
        if ((pa[p] < pb[p] ? pa[p] : pb[p]) < cch) cch = (pa[p] < pb[p]) ? pa[p] : pb[p];
      end
    e_done = 0;
    if (mst == 0) begin
      for (int i = 0; i < 4; i++) begin
        run[i] = 0;
        if (c[i] >= 0) begin hist[i] = c[i]; ycnt[i] = (c[i] == 2) ? 1 : 0; end
      end
      mst = 1;
    end else if (mst == 1) begin
      code = 0; fch = 0;
      if (conf) begin code = 1; fch = cch; end
      else begin
        for (int i = 3; i >= 0; i--) if (c[i] < 0 && run[i] + 1 >= GLITCH) begin code = 2; fch = i; end
        if (code == 0)
          for (int i = 3; i >= 0; i--)
            if (c[i] >= 0 && hist[i] >= 0 && c[i] != hist[i] && c[i] != (hist[i] + 1) % 3) begin
              code = 3; fch = i;
            end
        if (code == 0)
          for (int i = 3; i >= 0; i--)
            if (hist[i] == 2 && c[i] == 0 && ycnt[i] < MIN_YEL) begin code = 4; fch = i; end
      end
      e_done = (hist[1] == 2 && c[1] == 0) ? 1 : 0;
      if (e_done != 0) e_cnt = (e_cnt + 1) % 65536;
      for (int i = 0; i < 4; i++) begin
        if (c[i] < 0) run[i]++;
        else begin
          run[i]  = 0;
          ycnt[i] = (c[i] == 2) ? ycnt[i] + 1 : 0;
          hist[i] = c[i];
        end
      end
      if (code != 0) begin e_fault = 1; e_code = code; e_ch = fch; mst = 2; end
    end else begin
      if (clr && !conf) begin e_fault = 0; e_code = 0; e_ch = 0; mst = 0; end
    end
  endtask

  // one clock: drive at negedge, model the edge, compare 1 time unit after it
  task automatic step(input logic [2:0] m1, s, mt, m2, input logic clr);
    bus.light_M1 = m1; bus.light_S = s; bus.light_MT = mt; bus.light_M2 = m2;
    bus.clr_fault = clr;
    model_edge(clr);
    @(posedge clk);
    #1;
    q[0] = m1; q[1] = s; q[2] = mt; q[3] = m2;
    chk("fault", fault, e_fault);
    chk("flash_red", flash_red, e_fault);
    chk("fault_code", fault_code, e_code);
    chk("fault_ch", fault_ch, e_ch);
    chk("cycle_done", cycle_done, e_done);
`ifdef TLM_STATS_EN
    chk("cycle_cnt", cycle_cnt, e_cnt);
`endif
    if (cycle_done) dones++;
    @(negedge clk);
  endtask

  task automatic hold(input logic [2:0] m1, s, mt, m2, input int n);
    for (int k = 0; k < n; k++) step(m1, s, mt, m2, 1'b0);
  endtask

  task automatic clear_all_red();
    hold(R, R, R, R, 3);
    step(R, R, R, R, 1'b1);
    chk("clear_fault", fault, 0);
    hold(R, R, R, R, 2);
  endtask

  logic [2:0] cur[4];
  int r;

  initial begin
    rst_n = 1'b0;
    bus.light_M1 = R; bus.light_S = R; bus.light_MT = R; bus.light_M2 = R;
    bus.clr_fault = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_ch", fault_ch, 0);
    chk("rst_flash", flash_red, 0);
    chk("rst_done", cycle_done, 0);
    rst_n = 1'b1;

    // 1: three legal 6-phase cycles, yellow dwell at or above the minimum
    for (int k = 0; k < 3; k++) begin
      hold(G, R, R, G, $urandom_range(2, 6));
      hold(G, R, R, Y, $urandom_range(MIN_YEL, MIN_YEL + 4));
      hold(G, R, G, R, $urandom_range(2, 6));
      hold(Y, R, Y, R, $urandom_range(MIN_YEL, MIN_YEL + 4));
      hold(R, G, R, R, $urandom_range(2, 6));
      hold(R, Y, R, R, $urandom_range(MIN_YEL, MIN_YEL + 4));
    end
    hold(R, R, R, R, 2);
    chk("legal_fault", fault, 0);
    chk("legal_dones", dones, 3);
`ifdef TLM_STATS_EN
    chk("legal_cnt", cycle_cnt, 3);
`endif

    // 2: M1 and S green together
    step(G, G, R, R, 1'b0);
    step(G, G, R, R, 1'b0);
    chk("conf_fault", fault, 1);
    chk("conf_code", fault_code, 1);
    chk("conf_ch", fault_ch, 0);
    chk("conf_flash", flash_red, 1);
    clear_all_red();

    // 3: short yellow on M2
    hold(R, R, R, G, 3);
    hold(R, R, R, Y, 5);
    hold(R, R, R, R, 2);
    chk("yel_code", fault_code, 4);
    chk("yel_ch", fault_ch, 3);
    clear_all_red();

    // 4: M1 green straight to red
    hold(G, R, R, R, 3);
    hold(R, R, R, R, 2);
    chk("seq_code", fault_code, 3);
    chk("seq_ch", fault_ch, 0);
    clear_all_red();

    // 5: encoding glitch filter, below and at the threshold
    hold(R, BAD, R, R, GLITCH - 1);
    hold(R, R, R, R, 3);
    chk("glitch_short", fault, 0);
    hold(R, BAD, R, R, GLITCH);
    chk("enc_latency", fault, 0);
    step(R, BAD, R, R, 1'b0);
    chk("enc_fault", fault, 1);
    chk("enc_code", fault_code, 2);
    chk("enc_ch", fault_ch, 1);
    clear_all_red();

    // 6b: clear refused while conflict persists
    hold(G, G, R, R, 2);
    step(G, G, R, R, 1'b1);
    chk("noclr_fault", fault, 1);
    chk("noclr_code", fault_code, 1);
    clear_all_red();

    // random walk, every cycle checked against the model
    for (int i = 0; i < 4; i++) cur[i] = R;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) begin
          r = $urandom_range(0, 9);
          cur[i] = (r < 4) ? R : (r < 6) ? G : (r < 9) ? Y : 3'($urandom_range(0, 7));
        end
      step(cur[0], cur[1], cur[2], cur[3], ($urandom_range(0, 7) == 0));
    end

    // 6c: asynchronous reset mid-yellow while in FAULT
    clear_all_red();
    hold(R, R, R, G, 2);
    hold(R, R, R, Y, 2);
    hold(R, G, R, Y, 2);
    chk("pre_rst_fault", fault, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fault", fault, 0);
    chk("arst_code", fault_code, 0);
    chk("arst_ch", fault_ch, 0);
    chk("arst_flash", flash_red, 0);
    chk("arst_done", cycle_done, 0);
`ifdef TLM_STATS_EN
    chk("arst_cnt", cycle_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    hold(R, R, R, R, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
